// File: rtl/debug_view_ctrl.sv
// debug_view_ctrl
// Selects one of NUM_SRC debug sources for an LCD/hex display. The switches
// and the freeze button are synchronised and debounced. The displayed index
// comes from one of two places: the manual select switches, or (optionally)
// an auto-scan that steps through the sources. A freeze press holds the
// display until the next press.
//
// Optional feature: define DEBUG_VIEW_AUTOSCAN_EN to include the SCAN state
// and its dwell counter. Without it, scan_sw is ignored and the display is
// either manual or frozen.
//
// Ports
//   clock, reset_n   single clock, asynchronous active-low reset
//   sel_sw[3:0]      raw manual source select (clamped to NUM_SRC-1)
//   scan_sw          raw switch, 1 requests auto-scan
//   freeze_btn       raw button, each press toggles the freeze
//   src_data         NUM_SRC words of DATA_W bits, source k at [k*DATA_W +: DATA_W]
//   src_addr         NUM_SRC bytes, source k at [k*8 +: 8]
//   pc, clock_counter  shown in digits[23:16] (pc low byte) and digits[15:0]
//   lcd_data         registered word of the displayed source
//   digits[31:0]     {src_addr of displayed source, pc[7:0], clock_counter}
//   lcd_src          index of the displayed source
//   frozen           1 while the display is held
//   src_changed      one-cycle pulse in the cycle lcd_src takes a new value
module debug_view_ctrl #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_W       = 32,
    parameter int SCAN_DIV     = 50000000,
    parameter int DEBOUNCE_CYC = 65536
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [3:0]                sel_sw,
    input  logic                      scan_sw,
    input  logic                      freeze_btn,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC*8-1:0]      src_addr,
    input  logic [15:0]               pc,
    input  logic [15:0]               clock_counter,
    output logic [DATA_W-1:0]         lcd_data,
    output logic [31:0]               digits,
    output logic [3:0]                lcd_src,
    output logic                      frozen,
    output logic                      src_changed
);

`ifdef DEBUG_VIEW_AUTOSCAN_EN
    localparam int NUM_IN = 6;
    localparam int SC_W   = $clog2(SCAN_DIV + 1);
    localparam logic [SC_W-1:0] SCAN_LAST = SC_W'(SCAN_DIV - 1);
    typedef enum logic [1:0] {ST_MANUAL = 2'd0, ST_SCAN = 2'd1, ST_FROZEN = 2'd2} state_t;
`else
    localparam int NUM_IN = 5;
    typedef enum logic [1:0] {ST_MANUAL = 2'd0, ST_FROZEN = 2'd2} state_t;
`endif
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    // Raw input bits: [3:0] select, [4] freeze, [5] scan (when present).
    logic [NUM_IN-1:0] raw_s;
    logic [NUM_IN-1:0] sync1_r;
    logic [NUM_IN-1:0] sync2_r;
    logic [NUM_IN-1:0] deb_r;
    logic [DB_W-1:0]   db_cnt_r [NUM_IN];
    logic              frz_prev_r;

`ifdef DEBUG_VIEW_AUTOSCAN_EN
    assign raw_s = {scan_sw, freeze_btn, sel_sw};
`else
    logic unused_scan_s;
    assign raw_s         = {freeze_btn, sel_sw};
    assign unused_scan_s = scan_sw;
`endif

    logic [7:0] unused_pc_hi_s;
    assign unused_pc_hi_s = pc[15:8];

    // Two-flop synchroniser followed by a per-bit debounce: a bit only takes
    // its new level after DEBOUNCE_CYC consecutive samples that disagree with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r    <= '0;
            sync2_r    <= '0;
            deb_r      <= '0;
            frz_prev_r <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r    <= raw_s;
            sync2_r    <= sync1_r;
            frz_prev_r <= deb_r[4];
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    deb_r[i]    <= sync2_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    logic       press_s;
    logic [3:0] sel_clamp_s;
    assign press_s = deb_r[4] & ~frz_prev_r;

    // Clamp the debounced select into the valid source range; the compare is
    // one bit wider so that NUM_SRC=16 does not wrap to zero.
    always_comb begin
        if ({1'b0, deb_r[3:0]} >= 5'(NUM_SRC)) begin
            sel_clamp_s = 4'(NUM_SRC - 1);
        end else begin
            sel_clamp_s = deb_r[3:0];
        end
    end

    state_t     state_r;
    state_t     state_nx_s;
    logic [3:0] idx_nx_s;
`ifdef DEBUG_VIEW_AUTOSCAN_EN
    logic            scan_db_s;
    logic [SC_W-1:0] scan_cnt_r;
    logic [SC_W-1:0] scan_cnt_nx_s;
    assign scan_db_s = deb_r[5];
`endif

    // Next state, next displayed index and next scan count.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = lcd_src;
`ifdef DEBUG_VIEW_AUTOSCAN_EN
        scan_cnt_nx_s = scan_cnt_r;
`endif
        case (state_r)
            ST_MANUAL: begin
                idx_nx_s = sel_clamp_s;
                if (press_s) begin
                    state_nx_s = ST_FROZEN;
                    idx_nx_s   = lcd_src;
`ifdef DEBUG_VIEW_AUTOSCAN_EN
                end else if (scan_db_s) begin
                    state_nx_s    = ST_SCAN;
                    scan_cnt_nx_s = '0;
`endif
                end else begin
                    state_nx_s = ST_MANUAL;
                end
            end
`ifdef DEBUG_VIEW_AUTOSCAN_EN
            ST_SCAN: begin
                if (press_s) begin
                    state_nx_s = ST_FROZEN;
                end else if (!scan_db_s) begin
                    state_nx_s = ST_MANUAL;
                    idx_nx_s   = sel_clamp_s;
                end else if (scan_cnt_r == SCAN_LAST) begin
                    scan_cnt_nx_s = '0;
                    idx_nx_s      = (lcd_src == 4'(NUM_SRC - 1)) ? 4'd0 : lcd_src + 4'd1;
                end else begin
                    scan_cnt_nx_s = scan_cnt_r + SC_W'(1);
                end
            end
`endif
            ST_FROZEN: begin
                if (press_s) begin
`ifdef DEBUG_VIEW_AUTOSCAN_EN
                    if (scan_db_s) begin
                        state_nx_s    = ST_SCAN;
                        scan_cnt_nx_s = '0;
                    end else begin
                        state_nx_s = ST_MANUAL;
                        idx_nx_s   = sel_clamp_s;
                    end
`else
                    state_nx_s = ST_MANUAL;
                    idx_nx_s   = sel_clamp_s;
`endif
                end else begin
                    state_nx_s = ST_FROZEN;
                end
            end
            default: begin
                state_nx_s = ST_MANUAL;
                idx_nx_s   = 4'd0;
            end
        endcase
    end

    logic [DATA_W-1:0] sel_data_s;
    logic [7:0]        sel_addr_s;

    // Source word and address for the next displayed index.
    always_comb begin
        sel_data_s = '0;
        sel_addr_s = 8'h00;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (idx_nx_s == 4'(k)) begin
                sel_data_s = src_data[k*DATA_W +: DATA_W];
                sel_addr_s = src_addr[k*8 +: 8];
            end else begin
                sel_data_s = sel_data_s;
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // FSM state and all display outputs. Outputs are only reloaded when the
    // next state is not FROZEN, which is what holds them during a freeze.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_MANUAL;
            lcd_src     <= 4'd0;
            lcd_data    <= '0;
            digits      <= 32'h0000_0000;
            frozen      <= 1'b0;
            src_changed <= 1'b0;
`ifdef DEBUG_VIEW_AUTOSCAN_EN
            scan_cnt_r  <= '0;
`endif
        end else begin
            state_r <= state_nx_s;
            frozen  <= (state_nx_s == ST_FROZEN);
`ifdef DEBUG_VIEW_AUTOSCAN_EN
            scan_cnt_r <= scan_cnt_nx_s;
`endif
            if (state_nx_s != ST_FROZEN) begin
                lcd_src     <= idx_nx_s;
                lcd_data    <= sel_data_s;
                digits      <= {sel_addr_s, pc[7:0], clock_counter};
                src_changed <= (idx_nx_s != lcd_src);
            end else begin
                src_changed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_view_ctrl.sv
// Self-checking bench for debug_view_ctrl with NUM_SRC=3, SCAN_DIV=4,
// DEBOUNCE_CYC=3. A raw input change reaches lcd_src on the 6th rising edge
// after it is driven (2 sync flops, 3 debounce samples, 1 output register).
module tb_debug_view_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  sel_sw;
    logic        scan_sw;
    logic        freeze_btn;
    logic [31:0] sd [3];
    logic [7:0]  sa [3];
    logic [95:0] src_data;
    logic [23:0] src_addr;
    logic [15:0] pc;
    logic [15:0] clock_counter;
    logic [31:0] lcd_data;
    logic [31:0] digits;
    logic [3:0]  lcd_src;
    logic        frozen;
    logic        src_changed;

    assign src_data = {sd[2], sd[1], sd[0]};
    assign src_addr = {sa[2], sa[1], sa[0]};

    debug_view_ctrl #(
        .NUM_SRC(3), .DATA_W(32), .SCAN_DIV(4), .DEBOUNCE_CYC(3)
    ) dut (
        .clock(clock), .reset_n(reset_n), .sel_sw(sel_sw), .scan_sw(scan_sw),
        .freeze_btn(freeze_btn), .src_data(src_data), .src_addr(src_addr),
        .pc(pc), .clock_counter(clock_counter), .lcd_data(lcd_data),
        .digits(digits), .lcd_src(lcd_src), .frozen(frozen),
        .src_changed(src_changed)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  sel;
        int          hold;
        logic [3:0]  exp_src;
        logic [31:0] exp_data;
        logic [7:0]  exp_addr;
        int          exp_pulses;
    } vec_t;

    vec_t vt [7];
    vec_t sb [$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic steps(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
            pulses += int'(src_changed);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   p;
        int   acc;
        vec_t e;

        vt[0] = '{4'd2,  6, 4'd2, 32'hDEADBEEF, 8'h08, 1};
        vt[1] = '{4'd9,  6, 4'd2, 32'hDEADBEEF, 8'h08, 0};
        vt[2] = '{4'd1,  6, 4'd1, 32'h22221111, 8'h05, 1};
        vt[3] = '{4'd0,  5, 4'd1, 32'h22221111, 8'h05, 0};
        vt[4] = '{4'd0,  1, 4'd0, 32'h11110000, 8'h03, 1};
        vt[5] = '{4'd15, 6, 4'd2, 32'hDEADBEEF, 8'h08, 1};
        vt[6] = '{4'd1,  6, 4'd1, 32'h22221111, 8'h05, 1};

        reset_n = 1'b0; sel_sw = 4'd0; scan_sw = 1'b0; freeze_btn = 1'b0;
        sd[0] = 32'h11110000; sd[1] = 32'h22221111; sd[2] = 32'hDEADBEEF;
        sa[0] = 8'h03; sa[1] = 8'h05; sa[2] = 8'h08;
        pc = 16'h1234; clock_counter = 16'hABCD;

        steps(3, p);
        chk("reset lcd_data", lcd_data, 32'h0);
        chk("reset digits", digits, 32'h0);
        chk("reset lcd_src", {28'h0, lcd_src}, 32'h0);
        chk("reset frozen", {31'h0, frozen}, 32'h0);

        reset_n = 1'b1;
        steps(1, p);
        chk("first edge lcd_data", lcd_data, 32'h11110000);
        chk("first edge digits", digits, 32'h0334ABCD);
        chk("first edge src_changed", {31'h0, src_changed}, 32'h0);

        // Manual select table
        for (int i = 0; i < 7; i++) begin
            sel_sw = vt[i].sel;
            sb.push_back(vt[i]);
            steps(vt[i].hold, p);
            e = sb.pop_front();
            chk($sformatf("vec%0d lcd_src", i), {28'h0, lcd_src}, {28'h0, e.exp_src});
            chk($sformatf("vec%0d lcd_data", i), lcd_data, e.exp_data);
            chk($sformatf("vec%0d addr", i), {24'h0, digits[31:24]}, {24'h0, e.exp_addr});
            chk($sformatf("vec%0d pulses", i), p, e.exp_pulses);
        end

        // Two-cycle glitch to 0 must be rejected
        sel_sw = 4'd0;
        steps(2, p);
        acc = p;
        sel_sw = 4'd1;
        steps(8, p);
        acc += p;
        chk("glitch lcd_src", {28'h0, lcd_src}, 32'd1);
        chk("glitch pulses", acc, 0);

        // Data path has one cycle of latency
        sd[1] = 32'h5A5AA5A5; pc = 16'h1299;
        steps(1, p);
        chk("latency lcd_data", lcd_data, 32'h5A5AA5A5);
        chk("latency digits", digits, 32'h0599ABCD);

        // Freeze in manual, change inputs, unfreeze
        freeze_btn = 1'b1;
        steps(5, p);
        chk("freeze edge5 frozen", {31'h0, frozen}, 32'h0);
        steps(1, p);
        chk("freeze edge6 frozen", {31'h0, frozen}, 32'h1);
        freeze_btn = 1'b0; sel_sw = 4'd2; clock_counter = 16'h0F0F; sd[1] = 32'h77777777;
        steps(10, p);
        chk("held lcd_src", {28'h0, lcd_src}, 32'd1);
        chk("held lcd_data", lcd_data, 32'h5A5AA5A5);
        chk("held digits", digits, 32'h0599ABCD);
        chk("held frozen", {31'h0, frozen}, 32'h1);
        chk("held pulses", p, 0);
        freeze_btn = 1'b1;
        steps(6, p);
        chk("unfreeze frozen", {31'h0, frozen}, 32'h0);
        chk("unfreeze lcd_src", {28'h0, lcd_src}, 32'd2);
        chk("unfreeze lcd_data", lcd_data, 32'hDEADBEEF);
        chk("unfreeze digits", digits, 32'h08990F0F);
        chk("unfreeze pulses", p, 1);
        freeze_btn = 1'b0;
        sel_sw = 4'd1;
        steps(6, p);
        chk("back to src1", {28'h0, lcd_src}, 32'd1);

`ifdef DEBUG_VIEW_AUTOSCAN_EN
        // Auto-scan 1,2,0,1,2,0 then freeze at index 0 (press lands on edge 28)
        scan_sw = 1'b1;
        acc = 0;
        for (int k = 1; k <= 28; k++) begin
            if (k == 23) freeze_btn = 1'b1;
            steps(1, p);
            acc += p;
            case (k)
                5, 9:    chk($sformatf("scan k%0d", k), {28'h0, lcd_src}, 32'd1);
                10, 13:  chk($sformatf("scan k%0d", k), {28'h0, lcd_src}, 32'd2);
                14, 17:  chk($sformatf("scan k%0d", k), {28'h0, lcd_src}, 32'd0);
                18:      chk("scan k18", {28'h0, lcd_src}, 32'd1);
                22:      chk("scan k22", {28'h0, lcd_src}, 32'd2);
                27:      chk("scan k27 frozen", {31'h0, frozen}, 32'h0);
                28:      chk("scan k28 frozen", {31'h0, frozen}, 32'h1);
                default: acc = acc;
            endcase
        end
        chk("scan pulses", acc, 5);
        chk("scan frozen src", {28'h0, lcd_src}, 32'd0);
        freeze_btn = 1'b0; clock_counter = 16'h1357; sd[0] = 32'h99990000;
        steps(10, p);
        chk("scan held lcd_data", lcd_data, 32'h11110000);
        chk("scan held digits", digits, 32'h03990F0F);
        chk("scan held src", {28'h0, lcd_src}, 32'd0);
        freeze_btn = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            steps(1, p);
            case (j)
                5:       chk("resume j5 frozen", {31'h0, frozen}, 32'h1);
                6: begin
                    chk("resume j6 frozen", {31'h0, frozen}, 32'h0);
                    chk("resume j6 lcd_data", lcd_data, 32'h99990000);
                    chk("resume j6 digits", digits, 32'h03991357);
                end
                9:       chk("resume j9 src", {28'h0, lcd_src}, 32'd0);
                10:      chk("resume j10 src", {28'h0, lcd_src}, 32'd1);
                default: p = p;
            endcase
        end
        freeze_btn = 1'b0; scan_sw = 1'b0;
        steps(8, p);
        chk("scan exit src", {28'h0, lcd_src}, 32'd1);
`else
        // scan_sw has no effect when auto-scan is not built in
        scan_sw = 1'b1;
        steps(12, p);
        chk("noscan hold src", {28'h0, lcd_src}, 32'd1);
        chk("noscan pulses", p, 0);
        sel_sw = 4'd0;
        steps(6, p);
        chk("noscan follows sel", {28'h0, lcd_src}, 32'd0);
        chk("noscan lcd_data", lcd_data, 32'h11110000);
        scan_sw = 1'b0;
`endif

        // Asynchronous reset while frozen
        steps(6, p);
        freeze_btn = 1'b1;
        steps(7, p);
        chk("pre-reset frozen", {31'h0, frozen}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset lcd_data", lcd_data, 32'h0);
        chk("async reset digits", digits, 32'h0);
        chk("async reset lcd_src", {28'h0, lcd_src}, 32'h0);
        chk("async reset frozen", {31'h0, frozen}, 32'h0);
        chk("async reset src_changed", {31'h0, src_changed}, 32'h0);
        freeze_btn = 1'b0;
        steps(2, p);
        reset_n = 1'b1;
        steps(2, p);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
